// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - shared types, codes and lane helpers for the memory stage
//
// Purpose : FSM state encoding, funct3 access codes, trap bits and the
//           small pure functions used by mem_stage and mem_load_align.
// Ports   : none (package).

package mem_stage_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUS  = 1'b1
  } state_t;

  localparam logic [2:0] FN_LB  = 3'b000;
  localparam logic [2:0] FN_LH  = 3'b001;
  localparam logic [2:0] FN_LW  = 3'b010;
  localparam logic [2:0] FN_LBU = 3'b100;
  localparam logic [2:0] FN_LHU = 3'b101;
  localparam logic [2:0] FN_SB  = 3'b000;
  localparam logic [2:0] FN_SH  = 3'b001;
  localparam logic [2:0] FN_SW  = 3'b010;

  localparam logic [3:0] TRAP_MISALIGN = 4'b0100;
  localparam logic [3:0] TRAP_ACCESS   = 4'b1000;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_t;

  // Size lives in funct3[1:0]; the reserved codes 011/110/111 land on word.
  function automatic size_t access_size(input logic [2:0] fn);
    case (fn[1:0])
      2'b00:   return SZ_BYTE;
      2'b01:   return SZ_HALF;
      default: return SZ_WORD;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [2:0] fn, input logic [1:0] lo);
    case (access_size(fn))
      SZ_BYTE: return 1'b0;
      SZ_HALF: return lo[0];
      default: return |lo;
    endcase
  endfunction

  function automatic logic [3:0] lane_sel(input logic [2:0] fn, input logic [1:0] lo);
    case (access_size(fn))
      SZ_BYTE: return 4'b0001 << lo;
      SZ_HALF: return 4'b0011 << lo;
      default: return 4'b1111;
    endcase
  endfunction

  // Replicating store data lets the bus slave pick any lane without a shifter.
  function automatic logic [31:0] store_data(input logic [2:0] fn, input logic [31:0] data);
    case (access_size(fn))
      SZ_BYTE: return {4{data[7:0]}};
      SZ_HALF: return {2{data[15:0]}};
      default: return data;
    endcase
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// rtl/mem_load_align.sv - load lane extraction and sign/zero extension
//
// Purpose : Picks the addressed byte/half/word out of the bus read data and
//           extends it to 32 bits according to funct3.
// Ports   : fn      - funct3 of the load
//           addr_lo - low two bits of the effective address
//           data    - raw 32-bit bus read data
//           result  - aligned, extended load value

module mem_load_align
  import mem_stage_pkg::*;
(
  input  logic [2:0]  fn,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] data,
  output logic [31:0] result
);

  logic [31:0] shifted;

  always_comb begin
    shifted = data >> {addr_lo, 3'b000};
    result  = data;
    case (access_size(fn))
      SZ_BYTE: result = fn[2] ? {24'h0, shifted[7:0]}
                              : {{24{shifted[7]}}, shifted[7:0]};
      SZ_HALF: result = fn[2] ? {16'h0, shifted[15:0]}
                              : {{16{shifted[15]}}, shifted[15:0]};
      default: result = data;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - pipeline memory stage with a single-outstanding data bus master
//
// Purpose : Accepts EX results, runs at most one load/store on the data bus,
//           detects misalignment and bus errors, and registers WB outputs.
// Ports   : clk_i, rstn_i                 - clock, async active-low reset
//           valid_i .. is_trap_mem_i       - EX stage result
//           stall_o                        - EX must hold while a bus cycle runs
//           valid_o .. is_trap_mem_o       - registered WB result
//           dbus_*                         - data bus master (cyc/ack/err handshake)

module mem_stage
  import mem_stage_pkg::*;
(
  input  logic        clk_i,
  input  logic        rstn_i,

  input  logic        valid_i,
  input  logic [31:0] PC_mem_i,
  input  logic [4:0]  rd_mem_i,
  input  logic [31:0] alu_out_mem_i,
  input  logic [31:0] rs2_data_mem_i,
  input  logic        mem_en_i,
  input  logic        mem_we_i,
  input  logic [2:0]  mem_fn_i,
  input  logic [3:0]  trap_code_mem_i,
  input  logic        is_trap_mem_i,
  output logic        stall_o,

  output logic        valid_o,
  output logic [31:0] PC_mem_o,
  output logic [4:0]  rd_mem_o,
  output logic [31:0] result_mem_o,
  output logic [3:0]  trap_code_mem_o,
  output logic        is_trap_mem_o,

  output logic [31:0] dbus_addr_o,
  output logic [31:0] dbus_dat_o,
  output logic [3:0]  dbus_sel_o,
  output logic        dbus_we_o,
  output logic        dbus_cyc_o,
  input  logic [31:0] dbus_dat_i,
  input  logic        dbus_ack_i,
  input  logic        dbus_err_i
);

  state_t state_q, state_d;

  logic accept;
  logic start_bus;
  logic finish;
  logic misaligned;

  // Context of the outstanding bus access, replayed to WB on completion.
  logic [31:0] pc_q;
  logic [4:0]  rd_q;
  logic [31:0] addr_q;
  logic [2:0]  fn_q;
  logic        we_q;
  logic [3:0]  trap_q;

  logic [31:0] load_data;

  assign misaligned = is_misaligned(mem_fn_i, alu_out_mem_i[1:0]);
  assign stall_o    = (state_q == ST_BUS);

  mem_load_align u_load_align (
    .fn      (fn_q),
    .addr_lo (addr_q[1:0]),
    .data    (dbus_dat_i),
    .result  (load_data)
  );

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    start_bus = 1'b0;
    finish    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (valid_i) begin
          accept = 1'b1;
          // Upstream traps and misaligned accesses never reach the bus.
          if (mem_en_i && !is_trap_mem_i && !misaligned) begin
            start_bus = 1'b1;
            state_d   = ST_BUS;
          end
        end
      end
      ST_BUS: begin
        if (dbus_ack_i || dbus_err_i) begin
          finish  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      valid_o         <= 1'b0;
      PC_mem_o        <= '0;
      rd_mem_o        <= '0;
      result_mem_o    <= '0;
      trap_code_mem_o <= '0;
      is_trap_mem_o   <= 1'b0;
      dbus_addr_o     <= '0;
      dbus_dat_o      <= '0;
      dbus_sel_o      <= '0;
      dbus_we_o       <= 1'b0;
      dbus_cyc_o      <= 1'b0;
      pc_q            <= '0;
      rd_q            <= '0;
      addr_q          <= '0;
      fn_q            <= '0;
      we_q            <= 1'b0;
      trap_q          <= '0;
    end else begin
      valid_o <= (accept && !start_bus) || finish;

      // Results that complete without a bus cycle.
      if (accept && !start_bus) begin
        PC_mem_o     <= PC_mem_i;
        result_mem_o <= alu_out_mem_i;
        if (mem_en_i && !is_trap_mem_i) begin
          rd_mem_o        <= '0;
          trap_code_mem_o <= trap_code_mem_i | TRAP_MISALIGN;
          is_trap_mem_o   <= 1'b1;
        end else begin
          rd_mem_o        <= is_trap_mem_i ? 5'd0 : rd_mem_i;
          trap_code_mem_o <= trap_code_mem_i;
          is_trap_mem_o   <= is_trap_mem_i;
        end
      end

      if (start_bus) begin
        pc_q        <= PC_mem_i;
        rd_q        <= rd_mem_i;
        addr_q      <= alu_out_mem_i;
        fn_q        <= mem_fn_i;
        we_q        <= mem_we_i;
        trap_q      <= trap_code_mem_i;
        dbus_addr_o <= {alu_out_mem_i[31:2], 2'b00};
        dbus_dat_o  <= store_data(mem_fn_i, rs2_data_mem_i);
        dbus_sel_o  <= lane_sel(mem_fn_i, alu_out_mem_i[1:0]);
        dbus_we_o   <= mem_we_i;
        dbus_cyc_o  <= 1'b1;
      end

      if (finish) begin
        dbus_cyc_o <= 1'b0;
        dbus_we_o  <= 1'b0;
        dbus_sel_o <= '0;
        PC_mem_o   <= pc_q;
        // Error takes priority when the slave raises ack and err together.
        if (dbus_err_i) begin
          rd_mem_o        <= '0;
          result_mem_o    <= addr_q;
          trap_code_mem_o <= trap_q | TRAP_ACCESS;
          is_trap_mem_o   <= 1'b1;
        end else begin
          rd_mem_o        <= rd_q;
          result_mem_o    <= we_q ? 32'd0 : load_data;
          trap_code_mem_o <= trap_q;
          is_trap_mem_o   <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - directed scoreboard bench for mem_stage

module tb_mem_stage;

  logic        clk;
  logic        rstn;
  logic        valid_i;
  logic [31:0] pc_i;
  logic [4:0]  rd_i;
  logic [31:0] alu_i;
  logic [31:0] rs2_i;
  logic        en_i;
  logic        we_i;
  logic [2:0]  fn_i;
  logic [3:0]  code_i;
  logic        trap_i;
  logic        stall_o;
  logic        valid_o;
  logic [31:0] pc_o;
  logic [4:0]  rd_o;
  logic [31:0] result_o;
  logic [3:0]  code_o;
  logic        trap_o;
  logic [31:0] dbus_addr;
  logic [31:0] dbus_wdat;
  logic [3:0]  dbus_sel;
  logic        dbus_we;
  logic        dbus_cyc;
  logic [31:0] dbus_rdat;
  logic        dbus_ack;
  logic        dbus_err;

  mem_stage dut (
    .clk_i           (clk),
    .rstn_i          (rstn),
    .valid_i         (valid_i),
    .PC_mem_i        (pc_i),
    .rd_mem_i        (rd_i),
    .alu_out_mem_i   (alu_i),
    .rs2_data_mem_i  (rs2_i),
    .mem_en_i        (en_i),
    .mem_we_i        (we_i),
    .mem_fn_i        (fn_i),
    .trap_code_mem_i (code_i),
    .is_trap_mem_i   (trap_i),
    .stall_o         (stall_o),
    .valid_o         (valid_o),
    .PC_mem_o        (pc_o),
    .rd_mem_o        (rd_o),
    .result_mem_o    (result_o),
    .trap_code_mem_o (code_o),
    .is_trap_mem_o   (trap_o),
    .dbus_addr_o     (dbus_addr),
    .dbus_dat_o      (dbus_wdat),
    .dbus_sel_o      (dbus_sel),
    .dbus_we_o       (dbus_we),
    .dbus_cyc_o      (dbus_cyc),
    .dbus_dat_i      (dbus_rdat),
    .dbus_ack_i      (dbus_ack),
    .dbus_err_i      (dbus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [31:0] result;
    logic [3:0]  code;
    logic        is_trap;
  } exp_t;

  exp_t sb[$];
  int   n_cmp   = 0;
  int   n_bad   = 0;
  int   n_push  = 0;
  int   n_valid = 0;

  always @(negedge clk) begin
    if (rstn === 1'b1 && valid_o === 1'b1) n_valid++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] pc, input logic [4:0] rd, input logic [31:0] res,
                      input logic [3:0] code, input logic is_trap);
    exp_t e;
    e.pc = pc; e.rd = rd; e.result = res; e.code = code; e.is_trap = is_trap;
    sb.push_back(e);
    n_push++;
  endtask

  // Drive one EX result for a single cycle, starting at a falling edge.
  task automatic issue(input logic [31:0] pc, input logic [4:0] rd, input logic [31:0] alu,
                       input logic [31:0] rs2, input logic en, input logic we,
                       input logic [2:0] fn, input logic [3:0] code, input logic trap);
    valid_i = 1'b1; pc_i = pc; rd_i = rd; alu_i = alu; rs2_i = rs2;
    en_i = en; we_i = we; fn_i = fn; code_i = code; trap_i = trap;
    @(negedge clk);
    valid_i = 1'b0; en_i = 1'b0; we_i = 1'b0; trap_i = 1'b0; code_i = 4'd0;
  endtask

  task automatic expect_wb(input string tag, input int budget);
    exp_t e;
    int   n = 0;
    while (valid_o !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({tag, " valid_o"}, 32'(valid_o), 32'd1);
    if (valid_o === 1'b1) begin
      check({tag, " sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check({tag, " pc"},      pc_o,            e.pc);
        check({tag, " rd"},      32'(rd_o),       32'(e.rd));
        check({tag, " result"},  result_o,        e.result);
        check({tag, " code"},    32'(code_o),     32'(e.code));
        check({tag, " is_trap"}, 32'(trap_o),     32'(e.is_trap));
      end
    end
  endtask

  // Hold ack (or err) low for `waits` cycles of BUS, then complete.
  task automatic bus_reply(input string tag, input int waits, input logic [31:0] rdata,
                           input logic ack, input logic err, input logic [3:0] sel,
                           input logic [31:0] addr);
    int n_stall = 0;
    check({tag, " cyc"},  32'(dbus_cyc), 32'd1);
    check({tag, " sel"},  32'(dbus_sel), 32'(sel));
    check({tag, " addr"}, dbus_addr,     addr);
    for (int i = 0; i <= waits; i++) begin
      if (stall_o === 1'b1) n_stall++;
      if (i == waits) begin
        dbus_ack = ack; dbus_err = err; dbus_rdat = rdata;
      end
      @(negedge clk);
    end
    dbus_ack = 1'b0; dbus_err = 1'b0; dbus_rdat = 32'hA5A5_A5A5;
    check({tag, " stall_cycles"}, 32'(n_stall), 32'(waits + 1));
  endtask

  initial begin
    rstn = 1'b0; valid_i = 1'b0; pc_i = '0; rd_i = '0; alu_i = '0; rs2_i = '0;
    en_i = 1'b0; we_i = 1'b0; fn_i = '0; code_i = '0; trap_i = 1'b0;
    dbus_rdat = 32'hA5A5_A5A5; dbus_ack = 1'b0; dbus_err = 1'b0;

    repeat (3) @(negedge clk);
    check("rst valid_o",  32'(valid_o),  32'd0);
    check("rst stall_o",  32'(stall_o),  32'd0);
    check("rst cyc",      32'(dbus_cyc), 32'd0);
    check("rst we",       32'(dbus_we),  32'd0);
    check("rst sel",      32'(dbus_sel), 32'd0);
    check("rst is_trap",  32'(trap_o),   32'd0);
    check("rst result",   result_o,      32'd0);

    // ADD issued on the very first edge after reset release.
    rstn = 1'b1;
    push(32'h100, 5'd5, 32'h0000_1234, 4'd0, 1'b0);
    issue(32'h100, 5'd5, 32'h0000_1234, 32'h0, 1'b0, 1'b0, 3'b000, 4'd0, 1'b0);
    check("add cyc", 32'(dbus_cyc), 32'd0);
    expect_wb("add", 0);

    // LB at 0x103, 3 wait states, EX keeps presenting valid_i during the stall.
    push(32'h104, 5'd3, 32'hFFFF_FF80, 4'd0, 1'b0);
    issue(32'h104, 5'd3, 32'h0000_0103, 32'h0, 1'b1, 1'b0, 3'b000, 4'd0, 1'b0);
    valid_i = 1'b1; alu_i = 32'hDEAD_0000;
    check("lb we", 32'(dbus_we), 32'd0);
    bus_reply("lb", 3, 32'h80FF_FFFF, 1'b1, 1'b0, 4'b1000, 32'h0000_0100);
    valid_i = 1'b0;
    expect_wb("lb", 0);
    check("lb stall_after", 32'(stall_o),  32'd0);
    check("lb cyc_after",   32'(dbus_cyc), 32'd0);

    // SH at 0x202 with lane replication.
    push(32'h108, 5'd0, 32'h0, 4'd0, 1'b0);
    issue(32'h108, 5'd0, 32'h0000_0202, 32'h0000_ABCD, 1'b1, 1'b1, 3'b001, 4'd0, 1'b0);
    check("sh dat", dbus_wdat,    32'hABCD_ABCD);
    check("sh we",  32'(dbus_we), 32'd1);
    bus_reply("sh", 0, 32'h1111_1111, 1'b1, 1'b0, 4'b1100, 32'h0000_0200);
    expect_wb("sh", 0);

    // Misaligned LW: no bus cycle, rd suppressed.
    push(32'h10C, 5'd0, 32'h0000_0006, 4'b0100, 1'b1);
    issue(32'h10C, 5'd7, 32'h0000_0006, 32'h0, 1'b1, 1'b0, 3'b010, 4'd0, 1'b0);
    check("lwmis cyc",   32'(dbus_cyc), 32'd0);
    check("lwmis stall", 32'(stall_o),  32'd0);
    expect_wb("lwmis", 0);

    // LH signed and LHU zero-extended half loads.
    push(32'h110, 5'd4, 32'hFFFF_9ABC, 4'd0, 1'b0);
    issue(32'h110, 5'd4, 32'h0000_0400, 32'h0, 1'b1, 1'b0, 3'b001, 4'd0, 1'b0);
    bus_reply("lh", 1, 32'h1234_9ABC, 1'b1, 1'b0, 4'b0011, 32'h0000_0400);
    expect_wb("lh", 0);

    push(32'h114, 5'd6, 32'h0000_8765, 4'd0, 1'b0);
    issue(32'h114, 5'd6, 32'h0000_0402, 32'h0, 1'b1, 1'b0, 3'b101, 4'd0, 1'b0);
    bus_reply("lhu", 0, 32'h8765_4321, 1'b1, 1'b0, 4'b1100, 32'h0000_0400);
    expect_wb("lhu", 0);

    // Reserved funct3 behaves as a word access.
    push(32'h118, 5'd8, 32'hDEAD_BEEF, 4'd0, 1'b0);
    issue(32'h118, 5'd8, 32'h0000_0500, 32'h0, 1'b1, 1'b0, 3'b111, 4'd0, 1'b0);
    bus_reply("rsv", 2, 32'hDEAD_BEEF, 1'b1, 1'b0, 4'b1111, 32'h0000_0500);
    expect_wb("rsv", 0);

    // Upstream trap passes through with no bus cycle.
    push(32'h11C, 5'd0, 32'h0000_0007, 4'b0001, 1'b1);
    issue(32'h11C, 5'd9, 32'h0000_0007, 32'h0, 1'b1, 1'b0, 3'b010, 4'b0001, 1'b1);
    check("uptrap cyc", 32'(dbus_cyc), 32'd0);
    expect_wb("uptrap", 0);

    // LW with ack and err together: err wins.
    push(32'h120, 5'd0, 32'h0000_0300, 4'b1000, 1'b1);
    issue(32'h120, 5'd9, 32'h0000_0300, 32'h0, 1'b1, 1'b0, 3'b010, 4'd0, 1'b0);
    bus_reply("lwerr", 0, 32'h5555_5555, 1'b1, 1'b1, 4'b1111, 32'h0000_0300);
    expect_wb("lwerr", 0);

    // Reset pulsed in the middle of a bus cycle.
    issue(32'h124, 5'd2, 32'h0000_0600, 32'h0, 1'b1, 1'b0, 3'b010, 4'd0, 1'b0);
    check("midrst cyc_before", 32'(dbus_cyc), 32'd1);
    #2 rstn = 1'b0;
    #1;
    check("midrst cyc",   32'(dbus_cyc), 32'd0);
    check("midrst stall", 32'(stall_o),  32'd0);
    check("midrst sel",   32'(dbus_sel), 32'd0);
    check("midrst valid", 32'(valid_o),  32'd0);
    @(negedge clk);
    rstn = 1'b1;
    push(32'h128, 5'd1, 32'h0000_00AA, 4'd0, 1'b0);
    issue(32'h128, 5'd1, 32'h0000_00AA, 32'h0, 1'b0, 1'b0, 3'b000, 4'd0, 1'b0);
    expect_wb("post_rst", 0);

    repeat (2) @(negedge clk);
    check("sb drained",   32'(sb.size()), 32'd0);
    check("valid pulses", 32'(n_valid),   32'(n_push));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have one clock and an asynchronous active-low reset: clk_i input 1, rising-edge clock; rstn_i input 1, asynchronous active-low reset.
REQ-002 SHALL provide these ports from the EX stage:
- valid_i input 1: EX result valid.
- PC_mem_i input 32: instruction PC.
- rd_mem_i input 5: destination register.
- alu_out_mem_i input 32: ALU result or effective address.
- rs2_data_mem_i input 32: store data.
- mem_en_i input 1: instruction is a load or store.
- mem_we_i input 1: instruction is a store.
- mem_fn_i input 3: funct3 access size/sign.
- trap_code_mem_i input 4: upstream trap bits.
- is_trap_mem_i input 1: upstream trap flag.
- stall_o output 1: EX must hold its outputs.
REQ-003 SHALL provide these ports to the WB stage:
- valid_o output 1: WB data valid.
- PC_mem_o output 32: PC.
- rd_mem_o output 5: destination register.
- result_mem_o output 32: writeback data or fault address.
- trap_code_mem_o output 4: trap bits.
- is_trap_mem_o output 1: trap flag.
REQ-004 SHALL provide these data-bus ports:
- dbus_addr_o output 32: word-aligned address.
- dbus_dat_o output 32: write data.
- dbus_sel_o output 4: byte lanes.
- dbus_we_o output 1: write.
- dbus_cyc_o output 1: cycle/strobe.
- dbus_dat_i input 32: read data.
- dbus_ack_i input 1: transfer done.
- dbus_err_i input 1: bus error.

Function
REQ-005 SHALL implement a two-state FSM, IDLE and BUS. stall_o SHALL be 1 exactly when the state is BUS.
REQ-006 In IDLE, valid_i SHALL be sampled each cycle; all WB outputs SHALL be registered, giving 1-cycle latency; valid_o SHALL equal the previous cycle's accept condition.
REQ-007 For a non-memory op, or when is_trap_mem_i=1: no bus cycle; result_mem_o SHALL equal alu_out_mem_i; trap fields SHALL pass through unchanged.
REQ-008 Misalignment SHALL be defined as: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0. A misaligned access SHALL start no bus cycle. The outputs one cycle later SHALL be: is_trap=1, trap_code = trap_code_mem_i | TRAP_MISALIGN, result = address.
REQ-009 For an aligned memory op accepted at cycle T:
- From T+1, dbus_cyc_o=1 and the state is BUS.
- dbus_addr_o, dbus_dat_o, dbus_sel_o and dbus_we_o SHALL be registered and stable until ack or err.
REQ-010 Byte lanes SHALL be:
- Byte access: sel = 1<<addr[1:0].
- Half access: sel = 4'b0011<<addr[1:0].
- Word access: sel = 4'b1111.
- Store data SHALL be replicated across lanes (byte x4, half x2).
REQ-011 On dbus_ack_i in cycle T+k:
- The FSM SHALL return to IDLE and drop dbus_cyc_o.
- valid_o SHALL be 1 at T+k+1.
- For loads, the result SHALL be the selected lane: LB/LH sign-extended, LBU/LHU zero-extended, LW whole word. For stores, the result SHALL be 0.
REQ-012 On dbus_err_i, handling SHALL be identical to ack except: is_trap=1, trap_code |= TRAP_ACCESS, result = address. If ack and err are asserted together, err SHALL win.
REQ-013 Whenever is_trap_mem_o=1, rd_mem_o SHALL be 0 to suppress writeback.
REQ-014 Reserved mem_fn_i values (011, 110, 111) SHALL be treated as word access.
REQ-015 While in BUS, valid_i SHALL be ignored; valid_o SHALL stay 0 until the completion cycle.
REQ-016 A bus cycle SHALL last indefinitely until ack or err; there SHALL be no timeout.

Reset
REQ-017 While rstn_i=0, the block SHALL immediately enter IDLE and drive dbus_cyc_o=0, dbus_we_o=0, dbus_sel_o=0, valid_o=0, stall_o=0, is_trap_mem_o=0, and all other outputs to 0, including mid-transfer.
REQ-018 After reset release, the first valid_i SHALL be accepted on the first rising edge.

Structure
REQ-019 The shared package SHALL hold: the FSM state encoding; the mem_fn codes LB=000, LH=001, LW=010, LBU=100, LHU=101, SB=000, SH=001, SW=010; TRAP_MISALIGN=4'b0100; TRAP_ACCESS=4'b1000.
REQ-020 Load extraction and extension SHALL live in one combinational sub-module, mem_load_align.

Verification
REQ-021 Bench SHALL cover:
- ADD result 0x0000_1234, mem_en=0 -> next cycle valid_o=1, result 0x0000_1234, no dbus_cyc_o.
- LB at addr 0x103, bus returns 0x80FF_FFFF after 3 wait cycles -> sel 4'b1000, stall_o held 4 cycles, result 0xFFFF_FF80.
- SH addr 0x202, data 0x0000_ABCD -> dbus_dat_o 0xABCD_ABCD, sel 4'b1100, we=1, result 0, rd_mem_o 0.
- LW addr 0x0000_0006 -> no bus cycle, is_trap=1, trap_code 4'b0100, result 0x0000_0006.
- LW with err and ack in the same cycle -> trap_code 4'b1000, rd_mem_o 0; reset pulsed mid-transfer -> dbus_cyc_o=0 immediately.
